// File: rtl/enable_prescaler_pkg.sv
// Shared constants and helpers for the enable prescaler slice.
package enable_prescaler_pkg;

   localparam int ENABLE_DIVW_DEF    = 8;
   localparam int ENABLE_DIV_RST_DEF = 1;
   localparam int ENABLE_BASE_DEF    = 500;
   localparam int ENABLE_NCH_DEF     = 3;

   // Index width with a floor of one bit, so single-entry ranges still get a port.
   function automatic int idx_width(input int n);
      if (n <= 1) begin
         return 1;
      end else begin
         return $clog2(n);
      end
   endfunction

endpackage

// File: rtl/enable_prescaler_if.sv
// Control and enable-output bundle between the prescaler and its users.
interface enable_prescaler_if
   import enable_prescaler_pkg::*;
#(
   parameter int NCH  = ENABLE_NCH_DEF,
   parameter int DIVW = ENABLE_DIVW_DEF
);
   localparam int CHW = idx_width(NCH);

   logic            enable_run;
   logic            enable_sync;
   logic            enable_wr;
   logic [CHW-1:0]  enable_wr_ch;
   logic [DIVW-1:0] enable_wr_div;
   logic            enable_base_tick;
   logic [NCH-1:0]  enable_pulseout;
   logic [NCH-1:0]  enable_square;
   logic            enable_wr_err;

   modport master (
      output enable_run, enable_sync, enable_wr, enable_wr_ch, enable_wr_div,
      input  enable_base_tick, enable_pulseout, enable_square, enable_wr_err
   );

   modport slave (
      input  enable_run, enable_sync, enable_wr, enable_wr_ch, enable_wr_div,
      output enable_base_tick, enable_pulseout, enable_square, enable_wr_err
   );

endinterface

// File: rtl/enable_prescaler_channel.sv
// One prescaler channel: base-tick counter, shadow/active ratio, optional square
// wave (built only when ENABLE_PRESCALER_SQUARE_EN is defined).
module enable_prescaler_channel
   import enable_prescaler_pkg::*;
#(
   parameter int DIVW    = ENABLE_DIVW_DEF,
   parameter int DIV_RST = ENABLE_DIV_RST_DEF
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_tick,
   input  logic            i_sync,
   input  logic            i_wr,
   input  logic [DIVW-1:0] i_wr_div,
   output logic            o_pulse,
   output logic            o_square
);
   localparam logic [DIVW-1:0] RST_RATIO = DIVW'(DIV_RST);

   typedef struct packed {
      logic [DIVW-1:0] cnt;
      logic [DIVW-1:0] ratio;
      logic [DIVW-1:0] shadow;
   } ch_state_t;

   ch_state_t       r_st;
   logic            w_wrap;
   logic [DIVW-1:0] w_shadow_nxt;

   // An accepted write in the same cycle as a wrap or sync must win immediately.
   assign w_shadow_nxt = i_wr ? i_wr_div : r_st.shadow;
   assign w_wrap       = i_tick && (r_st.cnt == (r_st.ratio - DIVW'(1)));
   assign o_pulse      = w_wrap;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_st.cnt    <= DIVW'(0);
         r_st.ratio  <= RST_RATIO;
         r_st.shadow <= RST_RATIO;
      end else if (i_sync) begin
         r_st.cnt    <= DIVW'(0);
         r_st.ratio  <= w_shadow_nxt;
         r_st.shadow <= w_shadow_nxt;
      end else begin
         r_st.shadow <= w_shadow_nxt;
         if (w_wrap) begin
            r_st.cnt   <= DIVW'(0);
            r_st.ratio <= w_shadow_nxt;
         end else if (i_tick) begin
            r_st.cnt   <= r_st.cnt + DIVW'(1);
            r_st.ratio <= r_st.ratio;
         end else begin
            r_st.cnt   <= r_st.cnt;
            r_st.ratio <= r_st.ratio;
         end
      end
   end

`ifdef ENABLE_PRESCALER_SQUARE_EN
   logic r_sq;

   // Square flips on the edge that closes each pulse cycle.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sq <= 1'b0;
      end else if (i_sync) begin
         r_sq <= 1'b0;
      end else if (w_wrap) begin
         r_sq <= ~r_sq;
      end else begin
         r_sq <= r_sq;
      end
   end

   assign o_square = r_sq;
`else
   assign o_square = 1'b0;
`endif

endmodule

// File: rtl/enable_prescaler.sv
// Multi-channel enable generator: base divider plus NCH ratio channels.
// Square outputs are built only with ENABLE_PRESCALER_SQUARE_EN defined.
module enable_prescaler
   import enable_prescaler_pkg::*;
#(
   parameter int BASE_DIV = ENABLE_BASE_DEF,
   parameter int NCH      = ENABLE_NCH_DEF,
   parameter int DIVW     = ENABLE_DIVW_DEF,
   parameter int DIV_RST  = ENABLE_DIV_RST_DEF
) (
   input  logic              enable_clock,
   input  logic              enable_reset,
   enable_prescaler_if.slave bus
);
   localparam int              BW        = idx_width(BASE_DIV);
   localparam int              CHW       = idx_width(NCH);
   localparam logic [BW-1:0]   BASE_LAST = BW'(BASE_DIV - 1);
   localparam logic [CHW:0]    NCH_LIM   = (CHW + 1)'(NCH);

   logic [BW-1:0]  r_base_cnt;
   logic           r_wr_err;
   logic           w_base_wrap;
   logic           w_tick;
   logic           w_wr_valid;
   logic           w_wr_acc;
   logic [NCH-1:0] w_wr_hit;
   logic [NCH-1:0] w_pulse;
   logic [NCH-1:0] w_square;

   assign w_base_wrap = bus.enable_run && (r_base_cnt == BASE_LAST);
   // Reset and sync cycles never emit a tick, so no channel pulses either.
   assign w_tick      = w_base_wrap && !bus.enable_sync && !enable_reset;

   assign w_wr_valid  = ({1'b0, bus.enable_wr_ch} < NCH_LIM) && (bus.enable_wr_div != DIVW'(0));
   assign w_wr_acc    = bus.enable_wr && w_wr_valid;

   always_ff @(posedge enable_clock) begin
      if (enable_reset) begin
         r_base_cnt <= BW'(0);
      end else if (bus.enable_sync) begin
         r_base_cnt <= BW'(0);
      end else if (w_base_wrap) begin
         r_base_cnt <= BW'(0);
      end else if (bus.enable_run) begin
         r_base_cnt <= r_base_cnt + BW'(1);
      end else begin
         r_base_cnt <= r_base_cnt;
      end
   end

   always_ff @(posedge enable_clock) begin
      if (enable_reset) begin
         r_wr_err <= 1'b0;
      end else begin
         r_wr_err <= bus.enable_wr && !w_wr_valid;
      end
   end

   for (genvar k = 0; k < NCH; k++) begin : g_ch
      assign w_wr_hit[k] = w_wr_acc && (bus.enable_wr_ch == CHW'(k));

      enable_prescaler_channel #(
         .DIVW    (DIVW),
         .DIV_RST (DIV_RST)
      ) u_ch (
         .i_clk    (enable_clock),
         .i_rst    (enable_reset),
         .i_tick   (w_tick),
         .i_sync   (bus.enable_sync),
         .i_wr     (w_wr_hit[k]),
         .i_wr_div (bus.enable_wr_div),
         .o_pulse  (w_pulse[k]),
         .o_square (w_square[k])
      );
   end

   assign bus.enable_base_tick = w_tick;
   assign bus.enable_pulseout  = w_pulse;
   assign bus.enable_square    = w_square;
   assign bus.enable_wr_err    = r_wr_err;

endmodule

// File: tb/tb_enable_prescaler.sv
// Randomised and directed bench for enable_prescaler against an event-index model.
module tb_enable_prescaler;
   localparam int BASE_DIV = 4;
   localparam int NCH      = 3;
   localparam int DIVW     = 4;
   localparam int DIV_RST  = 1;

   logic clk;
   logic rst;

   enable_prescaler_if #(.NCH(NCH), .DIVW(DIVW)) bus ();

   enable_prescaler #(
      .BASE_DIV (BASE_DIV),
      .NCH      (NCH),
      .DIVW     (DIVW),
      .DIV_RST  (DIV_RST)
   ) dut (
      .enable_clock (clk),
      .enable_reset (rst),
      .bus          (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Model: run cycles since alignment, base ticks since alignment, and for
   // each channel the base-tick index at which its next pulse is due.
   int m_run;
   int m_n;
   int m_next [NCH];
   int m_shd  [NCH];
   int m_np   [NCH];
   bit m_err;

   logic           last_tick;
   logic [NCH-1:0] last_pulse;
   logic           last_err;

   task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_run = 0;
      m_n   = 0;
      m_err = 1'b0;
      for (int k = 0; k < NCH; k++) begin
         m_shd[k]  = DIV_RST;
         m_next[k] = DIV_RST;
         m_np[k]   = 0;
      end
   endtask

   // One clock: compare at the falling edge, advance the model, return after the rising edge.
   task automatic step();
      bit             e_tick;
      logic [NCH-1:0] e_pulse;
      logic [NCH-1:0] e_sq;
      int             ch;
      int             dv;
      bit             acc;
      @(negedge clk);
      e_tick = bus.enable_run && !bus.enable_sync && !rst && ((m_run % BASE_DIV) == BASE_DIV - 1);
      for (int k = 0; k < NCH; k++) begin
         e_pulse[k] = e_tick && ((m_n + 1) == m_next[k]);
`ifdef ENABLE_PRESCALER_SQUARE_EN
         e_sq[k] = m_np[k][0];
`else
         e_sq[k] = 1'b0;
`endif
      end
      last_tick  = bus.enable_base_tick;
      last_pulse = bus.enable_pulseout;
      last_err   = bus.enable_wr_err;
      chk_val("base_tick", 32'(bus.enable_base_tick), 32'(e_tick));
      chk_val("pulseout", 32'(bus.enable_pulseout), 32'(e_pulse));
      chk_val("square", 32'(bus.enable_square), 32'(e_sq));
      chk_val("wr_err", 32'(bus.enable_wr_err), 32'(m_err));
      if (rst) begin
         model_reset();
      end else begin
         ch    = int'(bus.enable_wr_ch);
         dv    = int'(bus.enable_wr_div);
         acc   = bus.enable_wr && (ch < NCH) && (dv != 0);
         m_err = bus.enable_wr && !acc;
         if (acc) m_shd[ch] = dv;
         if (bus.enable_sync) begin
            m_run = 0;
            m_n   = 0;
            for (int k = 0; k < NCH; k++) begin
               m_next[k] = m_shd[k];
               m_np[k]   = 0;
            end
         end else begin
            if (bus.enable_run) m_run++;
            if (e_tick) begin
               m_n++;
               for (int k = 0; k < NCH; k++) begin
                  if (e_pulse[k]) begin
                     m_next[k] = m_n + m_shd[k];
                     m_np[k]++;
                  end
               end
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic set_wr(input bit wr, input int ch, input int dv);
      bus.enable_wr     = wr;
      bus.enable_wr_ch  = 2'(ch);
      bus.enable_wr_div = 4'(dv);
   endtask

   initial begin
      rst             = 1'b1;
      bus.enable_run  = 1'b0;
      bus.enable_sync = 1'b0;
      set_wr(1'b0, 0, 0);
      model_reset();
      step();
      step();

      // 1: free run from reset, ticks at 3,7,11
      rst            = 1'b0;
      bus.enable_run = 1'b1;
      for (int i = 0; i < 12; i++) begin
         step();
         chk_val("s1_tick_sched", 32'(last_tick), 32'((i % 4) == 3));
      end

      // 2: retarget ch1 mid-period
      step();
      set_wr(1'b1, 1, 3);
      step();
      set_wr(1'b0, 0, 0);
      for (int i = 0; i < 40; i++) step();

      // 3: rejected writes
      set_wr(1'b1, 0, 0);
      step();
      set_wr(1'b0, 0, 0);
      step();
      chk_val("s3_err_div0", 32'(last_err), 32'd1);
      set_wr(1'b1, 3, 5);
      step();
      set_wr(1'b0, 0, 0);
      step();
      chk_val("s3_err_ch3", 32'(last_err), 32'd1);
      step();
      chk_val("s3_err_clear", 32'(last_err), 32'd0);
      for (int i = 0; i < 12; i++) step();

      // 4: freeze at base_cnt=2
      for (int i = 0; i < 8 && (m_run % BASE_DIV) != 2; i++) step();
      chk_val("s4_phase", 32'(m_run % BASE_DIV), 32'd2);
      bus.enable_run = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         chk_val("s4_frozen", 32'({last_tick, last_pulse}), 32'd0);
      end
      bus.enable_run = 1'b1;
      step();
      chk_val("s4_resume0", 32'(last_tick), 32'd0);
      step();
      chk_val("s4_resume1", 32'(last_tick), 32'd1);

      // 5: sync with ch2 ratio 2
      for (int i = 0; i < 3; i++) step();
      bus.enable_sync = 1'b1;
      set_wr(1'b1, 2, 2);
      step();
      chk_val("s5_sync_quiet", 32'({last_tick, last_pulse}), 32'd0);
      bus.enable_sync = 1'b0;
      set_wr(1'b0, 0, 0);
      for (int i = 0; i < 16; i++) begin
         step();
         chk_val("s5_ch2_sched", 32'(last_pulse[2]), 32'((i % 8) == 7));
      end

      // 6: reset with a pending ch1 write
      set_wr(1'b1, 1, 7);
      step();
      set_wr(1'b0, 0, 0);
      step();
      rst = 1'b1;
      step();
      chk_val("s6_rst_quiet", 32'({last_tick, last_pulse}), 32'd0);
      rst = 1'b0;
      for (int i = 0; i < 12; i++) begin
         step();
         chk_val("s6_ch1_ratio1", 32'(last_pulse[1]), 32'((i % 4) == 3));
      end

      // random soak
      for (int i = 0; i < 3000; i++) begin
         rst             = ($urandom_range(0, 299) == 0);
         bus.enable_run  = ($urandom_range(0, 7) != 0);
         bus.enable_sync = ($urandom_range(0, 59) == 0);
         set_wr($urandom_range(0, 5) == 0, int'($urandom_range(0, 3)), int'($urandom_range(0, 5)));
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
